hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core. It handles the hazards that operand forwarding cannot resolve: load-use stalls, taken-branch flushes and data-memory wait freezes.
- It drives the PC / IF/ID write enables, the ID/EX bubble and the flush controls.
- It keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/hazard_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding,
// register index width and the hard-wired zero register.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and data-memory freeze control
// with a sticky memory-timeout flag and performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_memRead,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    hz_state_e       state_q;
    hz_state_e       state_d;
    logic [TO_W-1:0] wait_q;
    logic [TO_W-1:0] wait_d;
    logic            to_q;
    logic            to_d;

    logic load_use;
    logic mem_stall;
    logic br_eff;
    logic lu_eff;

    assign load_use = id_ex_memRead && (id_ex_rd != X0) &&
                      ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (id_ex_rd == id_rs2)));

    assign mem_stall = dmem_req && !dmem_ready;

    // One-hot winners of the priority chain.
    assign br_eff = branch_taken && !mem_stall;
    assign lu_eff = load_use && !branch_taken && !mem_stall;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                mem_stall: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_freeze = 1'b1;
                end
                br_eff: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                lu_eff: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        to_d    = to_q;
        unique case (state_q)
            HZ_RUN: begin
                if (mem_stall) begin
                    state_d = HZ_MEM_WAIT;
                    wait_d  = TO_ONE;
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_q != TO_MAX) begin
                        wait_d = wait_q + TO_ONE;
                    end
                end else begin
                    state_d = HZ_RUN;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = HZ_RUN;
                wait_d  = '0;
            end
        endcase
        if (mem_stall && (wait_d == TO_MAX)) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            wait_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
        end
    end

    assign mem_timeout = to_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_stall || lu_eff),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_eff),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model
// compared on every falling edge.
module tb_hazard_ctrl;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] id_ex_rd = '0;
    logic       id_ex_memRead = 1'b0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    int m_stall = 0;
    int m_flush = 0;
    int m_consec = 0;
    bit m_to = 1'b0;

    hazard_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_ex_rd      (id_ex_rd),
        .id_ex_memRead (id_ex_memRead),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .pipe_freeze   (pipe_freeze),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit is_lu();
        return id_ex_memRead && (id_ex_rd != 0) &&
               ((id_uses_rs1 && id_ex_rd == id_rs1) ||
                (id_uses_rs2 && id_ex_rd == id_rs2));
    endfunction

    function automatic bit is_ms();
        return dmem_req && !dmem_ready;
    endfunction

    // {pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, freeze}
    function automatic logic [5:0] exp_ctrl();
        if (rst)               return 6'b110000;
        else if (is_ms())      return 6'b000001;
        else if (branch_taken) return 6'b110110;
        else if (is_lu())      return 6'b001000;
        else                   return 6'b110000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stall  = 0;
            m_flush  = 0;
            m_consec = 0;
            m_to     = 1'b0;
        end else if (is_ms()) begin
            m_consec = m_consec + 1;
            if (m_consec >= TIMEOUT) m_to = 1'b1;
            if (m_stall < CMAX) m_stall = m_stall + 1;
        end else begin
            m_consec = 0;
            if (branch_taken) begin
                if (m_flush < CMAX) m_flush = m_flush + 1;
            end else if (is_lu()) begin
                if (m_stall < CMAX) m_stall = m_stall + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        e = exp_ctrl();
        check("pc_write",     int'(pc_write),     int'(e[5]));
        check("if_id_write",  int'(if_id_write),  int'(e[4]));
        check("id_ex_bubble", int'(id_ex_bubble), int'(e[3]));
        check("if_id_flush",  int'(if_id_flush),  int'(e[2]));
        check("id_ex_flush",  int'(id_ex_flush),  int'(e[1]));
        check("pipe_freeze",  int'(pipe_freeze),  int'(e[0]));
        check("mem_timeout",  int'(mem_timeout),  int'(m_to));
        check("stall_cnt",    int'(stall_cnt),    m_stall);
        check("flush_cnt",    int'(flush_cnt),    m_flush);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_rd = '0; id_ex_memRead = 1'b0;
        branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        id_ex_memRead = 1'b1; id_ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        tick();
        tick();
        check("rst_pc_write",  int'(pc_write), 1);
        check("rst_freeze",    int'(pipe_freeze), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        rst = 1'b0;
        tick();
        check("idle_flush_cnt", int'(flush_cnt), 0);
        check("idle_timeout",   int'(mem_timeout), 0);

        set_lu();
        #1;
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_bubble",   int'(id_ex_bubble), 1);
        tick();
        check("lu_stall_cnt", int'(stall_cnt), 1);
        id_ex_memRead = 1'b0;
        #1;
        check("lu_clear_pc_write", int'(pc_write), 1);
        check("lu_clear_bubble",   int'(id_ex_bubble), 0);
        tick();

        idle();
        id_ex_memRead = 1'b1; id_ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        check("x0_pc_write", int'(pc_write), 1);
        tick();
        idle();
        id_ex_memRead = 1'b1; id_ex_rd = 5'd7;
        id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1;
        check("unused_pc_write", int'(pc_write), 1);
        tick();
        check("x0_stall_cnt", int'(stall_cnt), 1);

        idle();
        set_lu();
        branch_taken = 1'b1;
        #1;
        check("br_lu_flush",  int'(if_id_flush), 1);
        check("br_lu_bubble", int'(id_ex_bubble), 0);
        check("br_lu_pc",     int'(pc_write), 1);
        tick();
        check("br_flush_cnt", int'(flush_cnt), 1);
        check("br_stall_cnt", int'(stall_cnt), 1);

        idle();
        pulse_rst();
        branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_freeze", int'(pipe_freeze), 1);
            check("mw_flush",  int'(if_id_flush), 0);
            tick();
        end
        check("mw_stall_cnt", int'(stall_cnt), 3);
        dmem_ready = 1'b1;
        #1;
        check("mw_rel_freeze", int'(pipe_freeze), 0);
        check("mw_rel_flush",  int'(if_id_flush), 1);
        tick();
        check("mw_rel_flush_cnt", int'(flush_cnt), 1);
        check("mw_no_timeout",    int'(mem_timeout), 0);

        idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("to_flag", int'(mem_timeout), (i >= 4) ? 1 : 0);
        end
        check("to_stall_sat", int'(stall_cnt), CMAX);
        dmem_req = 1'b0;
        tick();
        check("to_sticky", int'(mem_timeout), 1);
        dmem_req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_pc_write",  int'(pc_write), 1);
        check("arst_freeze",    int'(pipe_freeze), 0);
        check("arst_timeout",   int'(mem_timeout), 0);
        check("arst_stall_cnt", int'(stall_cnt), 0);
        idle();
        #1 rst = 1'b0;
        tick();

        set_lu();
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sat_stall_cnt", int'(stall_cnt), (i < CMAX) ? i : CMAX);
        end
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
